id_reg: RTL and testbench
=========================

# id_reg

Decode stage register that sits directly downstream of the fetch stage register. It consumes the fetched PC/instruction/valid, decodes RV32I base formats, generates the immediate and register addresses, and registers them for the execute stage. It detects load-use hazards against the instruction currently in EX, inserting a bubble and stalling fetch. It also flushes on a taken branch.

## Interface
- ADDR_W, 32, PC width
- INSN_W, 32, instruction width (fixed RV32I encoding; other values unsupported)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all registered outputs
- cpu_en  in  1  0 = freeze all state (outputs hold)
- if_en  in  1  fetch output valid
- if_pc  in  ADDR_W  PC of if_insn
- if_insn  in  INSN_W  fetched instruction
- br_taken  in  1  taken branch/jump resolved in EX; flush
- ex_en  in  1  EX stage holds a valid instruction
- ex_mem_rd  in  1  EX instruction is a load
- ex_rd_addr  in  5  EX destination register
- stall  out  1  combinational; fetch must hold if_pc/if_insn/if_en this cycle
- id_en  out  1  decode output valid
- id_pc  out  ADDR_W  registered PC
- id_insn  out  INSN_W  registered raw instruction
- id_rs1_addr, id_rs2_addr, id_rd_addr  out  5 each  register addresses (0 when unused)
- id_imm  out  32  sign-extended immediate
- id_fmt  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal
- id_funct3  out  3  insn[14:12]
- id_funct7_b5  out  1  insn[30]
- id_rd_we, id_mem_rd, id_mem_wr, id_illegal  out  1 each  control flags

## Operation
- Opcode map (insn[6:0]): 0110111 LUI U; 0010111 AUIPC U; 1101111 JAL J; 1100111 JALR I; 1100011 BRANCH B; 0000011 LOAD I; 0100011 STORE S; 0010011 OP-IMM I; 0110011 OP R. Any other value → illegal.
- Immediates:
  - I: sext(insn[31:20])
  - S: sext({insn[31:25],insn[11:7]})
  - B: sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0})
  - U: {insn[31:12],12'b0}
  - J: sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0})
  - R/illegal: 0
- Register use:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - Unused fields output 0.
- rd: written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP. id_rd_we = writes && rd != 0. id_rd_addr = insn[11:7] when written, else 0.
- id_mem_rd = LOAD; id_mem_wr = STORE.
- Illegal: id_illegal=1, id_fmt=7, all other controls 0. id_en still 1 so EX can trap.
- Hazard: stall = if_en && ex_en && ex_mem_rd && ex_rd_addr != 0 && ((rs1 used && rs1 == ex_rd_addr) || (rs2 used && rs2 == ex_rd_addr)) && !br_taken && cpu_en.
- Register update priority: reset > !cpu_en (hold) > br_taken (bubble) > stall (bubble) > latch decode of if_* with id_en=if_en.
- Bubble: id_en=0 and all control flags 0. id_pc/id_insn/fields may take any value; verification checks only controls on bubbles.
- if_en=0: latched with id_en=0 and controls 0.

## Timing
- Reset values: all outputs 0. stall=0 while reset is asserted.
- Decode latency: 1 cycle. if_* sampled at edge N appears on id_* after edge N.
- stall is combinational from inputs in the same cycle. There is no path from id_* to stall.
- Load-use costs exactly 1 bubble. After the bubble, ex_en=0, so the held instruction latches on the next edge.
- br_taken with stall in the same cycle: stall=0, bubble inserted, fetch free to redirect.
- br_taken during cpu_en=0: ignored; state holds.
- Reset asserted mid-stall: outputs 0 on the next edge, and the stall is dropped.

## Test plan
- Reset: assert reset 2 cycles with arbitrary inputs → all id_* = 0, stall = 0.
- addi x1,x2,-1 (0xFFF10093) at if_pc=0x100, if_en=1 → next cycle: id_en=1, id_pc=0x100, rs1=2, rs2=0, rd=1, imm=0xFFFFFFFF, fmt=1, rd_we=1.
- beq x1,x2,-4 (0xFE208EE3) → imm=0xFFFFFFFC, fmt=3, rs1=1, rs2=2, rd_we=0, rd=0.
- Load-use: ex_en=1, ex_mem_rd=1, ex_rd_addr=5; incoming add x6,x5,x7 (0x00728333) → stall=1 that cycle and id_en=0 next. Then drop ex_en → add latched with rd=6, fmt=0.
- Same as the load-use case but ex_rd_addr=0, or ex_rd_addr=7 with an I-type consumer (rs2 unused) → stall=0, no bubble.
- br_taken together with a hazard → stall=0, id_en=0. Separately, if_insn=0xFFFFFFFF → id_illegal=1, fmt=7, id_en=1, rd_we=0.

Source files
------------

// File: rtl/id_reg.sv
// Decode stage register: decodes RV32I formats, immediates and register fields, and registers them for EX.
// Ports: fetch inputs (if_*), EX hazard/flush inputs (ex_*, br_taken), combinational stall, registered id_* outputs.
// Latency 1 cycle; stall holds fetch for one bubble on a load-use hazard; cpu_en=0 freezes all state.
module id_reg #(
    parameter int ADDR_W = 32,
    parameter int INSN_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INSN_W-1:0] if_insn,
    input  logic              br_taken,
    input  logic              ex_en,
    input  logic              ex_mem_rd,
    input  logic [4:0]        ex_rd_addr,
    output logic              stall,
    output logic              id_en,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INSN_W-1:0] id_insn,
    output logic [4:0]        id_rs1_addr,
    output logic [4:0]        id_rs2_addr,
    output logic [4:0]        id_rd_addr,
    output logic [31:0]       id_imm,
    output logic [2:0]        id_fmt,
    output logic [2:0]        id_funct3,
    output logic              id_funct7_b5,
    output logic              id_rd_we,
    output logic              id_mem_rd,
    output logic              id_mem_wr,
    output logic              id_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [31:0] insn;
    logic [2:0]  d_fmt;
    logic [31:0] d_imm;
    logic        d_rs1_use, d_rs2_use, d_rd_wr;
    logic        d_mem_rd, d_mem_wr, d_illegal;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        d_rd_we;
    logic        hazard;

    assign insn = if_insn[31:0];

    // Format, register usage and memory flags from the opcode; anything unlisted is illegal.
    always_comb begin
        d_fmt     = FMT_ILL;
        d_rs1_use = 1'b0;
        d_rs2_use = 1'b0;
        d_rd_wr   = 1'b0;
        d_mem_rd  = 1'b0;
        d_mem_wr  = 1'b0;
        d_illegal = 1'b0;
        case (insn[6:0])
            OP_LUI, OP_AUIPC: begin d_fmt = FMT_U; d_rd_wr = 1'b1; end
            OP_JAL:           begin d_fmt = FMT_J; d_rd_wr = 1'b1; end
            OP_JALR:          begin d_fmt = FMT_I; d_rs1_use = 1'b1; d_rd_wr = 1'b1; end
            OP_BRANCH:        begin d_fmt = FMT_B; d_rs1_use = 1'b1; d_rs2_use = 1'b1; end
            OP_LOAD:          begin d_fmt = FMT_I; d_rs1_use = 1'b1; d_rd_wr = 1'b1; d_mem_rd = 1'b1; end
            OP_STORE:         begin d_fmt = FMT_S; d_rs1_use = 1'b1; d_rs2_use = 1'b1; d_mem_wr = 1'b1; end
            OP_OPIMM:         begin d_fmt = FMT_I; d_rs1_use = 1'b1; d_rd_wr = 1'b1; end
            OP_OP:            begin d_fmt = FMT_R; d_rs1_use = 1'b1; d_rs2_use = 1'b1; d_rd_wr = 1'b1; end
            default:          d_illegal = 1'b1;
        endcase
    end

    // Immediate assembly per format; R and illegal carry no immediate.
    always_comb begin
        d_imm = 32'd0;
        case (d_fmt)
            FMT_I:   d_imm = {{20{insn[31]}}, insn[31:20]};
            FMT_S:   d_imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            FMT_B:   d_imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            FMT_U:   d_imm = {insn[31:12], 12'd0};
            FMT_J:   d_imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: d_imm = 32'd0;
        endcase
    end

    assign d_rs1   = d_rs1_use ? insn[19:15] : 5'd0;
    assign d_rs2   = d_rs2_use ? insn[24:20] : 5'd0;
    assign d_rd    = d_rd_wr   ? insn[11:7]  : 5'd0;
    assign d_rd_we = d_rd_wr && (insn[11:7] != 5'd0);

    // Unused source fields are already zeroed, so with ex_rd_addr != 0 a plain
    // compare against the zeroed address cannot match an unused field.
    assign hazard = if_en && ex_en && ex_mem_rd && (ex_rd_addr != 5'd0) &&
                    ((d_rs1 == ex_rd_addr) || (d_rs2 == ex_rd_addr));

    // A taken branch discards the consumer anyway, so it never needs to stall.
    assign stall = hazard && !br_taken && cpu_en && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_en        <= 1'b0;
            id_pc        <= '0;
            id_insn      <= '0;
            id_rs1_addr  <= 5'd0;
            id_rs2_addr  <= 5'd0;
            id_rd_addr   <= 5'd0;
            id_imm       <= 32'd0;
            id_fmt       <= 3'd0;
            id_funct3    <= 3'd0;
            id_funct7_b5 <= 1'b0;
            id_rd_we     <= 1'b0;
            id_mem_rd    <= 1'b0;
            id_mem_wr    <= 1'b0;
            id_illegal   <= 1'b0;
        end else if (cpu_en) begin
            if (br_taken || stall) begin
                // Bubble: only the valid and control flags matter downstream.
                id_en      <= 1'b0;
                id_rd_we   <= 1'b0;
                id_mem_rd  <= 1'b0;
                id_mem_wr  <= 1'b0;
                id_illegal <= 1'b0;
            end else begin
                id_en        <= if_en;
                id_pc        <= if_pc;
                id_insn      <= if_insn;
                id_rs1_addr  <= d_rs1;
                id_rs2_addr  <= d_rs2;
                id_rd_addr   <= d_rd;
                id_imm       <= d_imm;
                id_fmt       <= d_fmt;
                id_funct3    <= insn[14:12];
                id_funct7_b5 <= insn[30];
                id_rd_we     <= if_en && d_rd_we;
                id_mem_rd    <= if_en && d_mem_rd;
                id_mem_wr    <= if_en && d_mem_wr;
                id_illegal   <= if_en && d_illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_reg.sv
module tb_id_reg;

    typedef struct packed {
        logic        en;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [2:0]  f3;
        logic        f7;
        logic        we;
        logic        mr;
        logic        mw;
        logic        ill;
    } out_t;

    logic        clk = 1'b0;
    logic        reset, cpu_en, if_en, br_taken, ex_en, ex_mem_rd;
    logic [31:0] if_pc, if_insn;
    logic [4:0]  ex_rd_addr;
    logic        stall, id_en, id_funct7_b5, id_rd_we, id_mem_rd, id_mem_wr, id_illegal;
    logic [31:0] id_pc, id_insn, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [2:0]  id_fmt, id_funct3;
    out_t        got;
    int          checks = 0;
    int          failures = 0;

    id_reg #(.ADDR_W(32), .INSN_W(32)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .if_en(if_en), .if_pc(if_pc),
        .if_insn(if_insn), .br_taken(br_taken), .ex_en(ex_en), .ex_mem_rd(ex_mem_rd),
        .ex_rd_addr(ex_rd_addr), .stall(stall), .id_en(id_en), .id_pc(id_pc),
        .id_insn(id_insn), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_imm(id_imm), .id_fmt(id_fmt), .id_funct3(id_funct3),
        .id_funct7_b5(id_funct7_b5), .id_rd_we(id_rd_we), .id_mem_rd(id_mem_rd),
        .id_mem_wr(id_mem_wr), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    assign got = {id_en, id_pc, id_insn, id_rs1_addr, id_rs2_addr, id_rd_addr, id_imm,
                  id_fmt, id_funct3, id_funct7_b5, id_rd_we, id_mem_rd, id_mem_wr, id_illegal};

    // Reference decode, written from the instruction-set rules with integer arithmetic.
    function automatic out_t model(input logic [31:0] pc, input logic [31:0] insn);
        out_t o;
        logic u1, u2, w;
        int   v;
        o = '0; u1 = 0; u2 = 0; w = 0; v = 0;
        o.en = 1'b1; o.pc = pc; o.insn = insn; o.f3 = insn[14:12]; o.f7 = insn[30];
        case (insn[6:0])
            7'h37, 7'h17: begin o.fmt = 3'd4; w = 1; end
            7'h6F: begin o.fmt = 3'd5; w = 1; end
            7'h67: begin o.fmt = 3'd1; u1 = 1; w = 1; end
            7'h63: begin o.fmt = 3'd3; u1 = 1; u2 = 1; end
            7'h03: begin o.fmt = 3'd1; u1 = 1; w = 1; o.mr = 1; end
            7'h23: begin o.fmt = 3'd2; u1 = 1; u2 = 1; o.mw = 1; end
            7'h13: begin o.fmt = 3'd1; u1 = 1; w = 1; end
            7'h33: begin o.fmt = 3'd0; u1 = 1; u2 = 1; w = 1; end
            default: begin o.fmt = 3'd7; o.ill = 1; end
        endcase
        case (o.fmt)
            3'd1: begin v = int'(insn[31:20]); if (v >= 2048) v -= 4096; end
            3'd2: begin v = int'(insn[31:25]) * 32 + int'(insn[11:7]); if (v >= 2048) v -= 4096; end
            3'd3: begin
                v = int'(insn[31]) * 4096 + int'(insn[7]) * 2048 + int'(insn[30:25]) * 32 + int'(insn[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd4: v = int'(insn & 32'hFFFF_F000);
            3'd5: begin
                v = int'(insn[31]) * 1048576 + int'(insn[19:12]) * 4096 + int'(insn[20]) * 2048 + int'(insn[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
        endcase
        o.imm = v;
        o.rs1 = u1 ? insn[19:15] : 5'd0;
        o.rs2 = u2 ? insn[24:20] : 5'd0;
        o.rd  = w  ? insn[11:7]  : 5'd0;
        o.we  = w && (insn[11:7] != 5'd0);
        return o;
    endfunction

    function automatic logic [4:0] ctl(input out_t o);
        return {o.en, o.we, o.mr, o.mw, o.ill};
    endfunction

    task automatic drive(input logic en, input logic [31:0] pc, input logic [31:0] insn,
                         input logic br, input logic xen, input logic xmr, input logic [4:0] xrd);
        if_en = en; if_pc = pc; if_insn = insn; br_taken = br;
        ex_en = xen; ex_mem_rd = xmr; ex_rd_addr = xrd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        out_t zero;
        zero = '0;
        reset = 1; cpu_en = 1;
        drive(1, 32'h200, 32'h00728333, 0, 1, 1, 5'd5);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        tick(); tick();
        checks++;
        if (got !== zero) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, zero); end
        reset = 0;
    endtask

    task automatic test_addi();
        out_t exp;
        drive(1, 32'h100, 32'hFFF10093, 0, 0, 0, 5'd0);
        exp = model(32'h100, 32'hFFF10093);
        tick();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL addi got=%h exp=%h", got, exp); end
        checks++;
        if ({id_imm, id_rs1_addr, id_rd_addr, id_fmt, id_rd_we} !== {32'hFFFF_FFFF, 5'd2, 5'd1, 3'd1, 1'b1}) begin
            failures++; $display("FAIL addi_fields got imm=%h rs1=%0d rd=%0d fmt=%0d we=%b", id_imm, id_rs1_addr, id_rd_addr, id_fmt, id_rd_we);
        end
    endtask

    task automatic test_beq();
        out_t exp;
        drive(1, 32'h104, 32'hFE208EE3, 0, 0, 0, 5'd0);
        exp = model(32'h104, 32'hFE208EE3);
        tick();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL beq got=%h exp=%h", got, exp); end
        checks++;
        if ({id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr, id_fmt, id_rd_we} !== {32'hFFFF_FFFC, 5'd1, 5'd2, 5'd0, 3'd3, 1'b0}) begin
            failures++; $display("FAIL beq_fields got imm=%h fmt=%0d", id_imm, id_fmt);
        end
    endtask

    task automatic test_load_use();
        out_t exp;
        drive(1, 32'h108, 32'h00728333, 0, 1, 1, 5'd5);
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
        tick();
        checks++;
        if (ctl(got) !== 5'b0) begin failures++; $display("FAIL lu_bubble got=%b exp=00000", ctl(got)); end
        drive(1, 32'h108, 32'h00728333, 0, 0, 0, 5'd0);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", stall); end
        exp = model(32'h108, 32'h00728333);
        tick();
        checks++;
        if (got !== exp || id_rd_addr !== 5'd6 || id_fmt !== 3'd0) begin
            failures++; $display("FAIL lu_latch got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_no_hazard();
        out_t exp;
        drive(1, 32'h10C, 32'h00728333, 0, 1, 1, 5'd0);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL nh_rd0 got=%b exp=0", stall); end
        exp = model(32'h10C, 32'h00728333);
        tick();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL nh_rd0_latch got=%h exp=%h", got, exp); end
        drive(1, 32'h110, 32'h00728313, 0, 1, 1, 5'd7);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL nh_rs2_unused got=%b exp=0", stall); end
        exp = model(32'h110, 32'h00728313);
        tick();
        checks++;
        if (got !== exp) begin failures++; $display("FAIL nh_itype_latch got=%h exp=%h", got, exp); end
    endtask

    task automatic test_branch_flush();
        drive(1, 32'h114, 32'h00728333, 1, 1, 1, 5'd5);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL br_stall got=%b exp=0", stall); end
        tick();
        checks++;
        if (ctl(got) !== 5'b0) begin failures++; $display("FAIL br_bubble got=%b exp=00000", ctl(got)); end
    endtask

    task automatic test_illegal();
        out_t exp;
        drive(1, 32'h118, 32'hFFFF_FFFF, 0, 0, 0, 5'd0);
        exp = model(32'h118, 32'hFFFF_FFFF);
        tick();
        checks++;
        if (got !== exp || {id_illegal, id_fmt, id_en, id_rd_we} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
            failures++; $display("FAIL illegal got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_freeze();
        out_t held;
        drive(1, 32'h11C, 32'h0002A303, 0, 0, 0, 5'd0);   // lw x6,0(x5)
        tick();
        held = got;
        cpu_en = 0;
        drive(1, 32'h120, 32'h00628333, 1, 1, 1, 5'd6);
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL frz_stall got=%b exp=0", stall); end
        tick();
        checks++;
        if (got !== model(32'h11C, 32'h0002A303)) begin failures++; $display("FAIL frz_hold got=%h exp=%h", got, held); end
        cpu_en = 1;
    endtask

    task automatic test_reset_mid_stall();
        out_t zero;
        zero = '0;
        drive(1, 32'h124, 32'h00728333, 0, 1, 1, 5'd7);
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL rms_stall got=%b exp=1", stall); end
        reset = 1; #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL rms_drop got=%b exp=0", stall); end
        tick();
        checks++;
        if (got !== zero) begin failures++; $display("FAIL rms_outputs got=%h exp=%h", got, zero); end
        reset = 0;
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        out_t exp, md;
        logic bub, en, br, xen, xmr, ce, es;
        logic [4:0] xrd;
        logic [31:0] insn, pc;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        exp = '0; bub = 1;
        for (int i = 0; i < 400; i++) begin
            insn = $urandom;
            insn[6:0] = ops[$urandom_range(0, 9)];
            insn[19:15] = 5'($urandom_range(0, 3));
            insn[24:20] = 5'($urandom_range(0, 3));
            pc = $urandom;
            en = ($urandom_range(0, 7) != 0);
            br = ($urandom_range(0, 9) == 0);
            xen = $urandom_range(0, 1);
            xmr = $urandom_range(0, 1);
            xrd = 5'($urandom_range(0, 3));
            ce = ($urandom_range(0, 9) != 0);
            cpu_en = ce;
            drive(en, pc, insn, br, xen, xmr, xrd);
            md = model(pc, insn);
            es = en && xen && xmr && xrd != 0 && (md.rs1 == xrd || md.rs2 == xrd) && !br && ce;
            checks++;
            if (stall !== es) begin failures++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, stall, es); end
            if (ce) begin
                if (br || es) bub = 1;
                else begin
                    exp = md;
                    bub = !en;
                end
            end
            tick();
            checks++;
            if (bub) begin
                if (ctl(got) !== 5'b0) begin failures++; $display("FAIL rnd_bubble[%0d] got=%b exp=00000", i, ctl(got)); end
            end else if (got !== exp) begin
                failures++; $display("FAIL rnd_decode[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        cpu_en = 1;
    endtask

    initial begin
        reset = 1; cpu_en = 1;
        drive(0, 32'h0, 32'h0, 0, 0, 0, 5'd0);
        test_reset();
        test_addi();
        test_beq();
        test_load_use();
        test_no_hazard();
        test_branch_flush();
        test_illegal();
        test_freeze();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
